// File: rtl/slow_sample_fifo_if.sv
// Read-side handshake bundle for slow_sample_fifo: head-of-queue sample plus valid/ready.
// A transfer happens on a rising clk edge where out_valid && out_ready; the master holds
// out_data stable while out_valid=1 and out_ready=0, and out_valid never depends on out_ready.
interface slow_sample_fifo_if #(
  parameter int S = 12
);
  logic [S-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/slow_sample_fifo.sv
// Slow-domain decimator + first-word-fall-through FIFO for synchronised samples,
// with fill level, sticky overflow and a saturating drop counter.
module slow_sample_fifo #(
  parameter int S     = 12,
  parameter int DEPTH = 16,
  parameter int DW    = 8,
  localparam int LW   = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                en,
  input  logic [DW-1:0]       decim,
  input  logic [S-1:0]        data_in,
  slow_sample_fifo_if.master  rd,
  output logic [LW-1:0]       level,
  output logic                overflow,
  output logic [DW-1:0]       drop_cnt,
  input  logic                clr_ovf
);

  logic [DW-1:0] cnt_q;
  logic [DW-1:0] n_minus1;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_nxt;
  logic [S-1:0]  head_q;
  logic [S-1:0]  head_nxt;
  logic          valid_q;
  logic          overflow_q;
  logic [DW-1:0] drop_cnt_q;
  logic [S-1:0]  mem [DEPTH];

  logic push_req;
  logic pop;
  logic push;
  logic full;
  logic drop;

  // DECIM==0 behaves like DECIM==1 (keep every sample).
  assign n_minus1 = (decim == '0) ? '0 : decim - DW'(1);
  assign push_req = en && (cnt_q == '0);
  assign full     = (level_q == LW'(DEPTH));
  assign pop      = valid_q && rd.out_ready;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q >= n_minus1) ? '0 : cnt_q + DW'(1);
    end
  end

  always_comb begin
    level_nxt = level_q;
    case ({push, pop})
      2'b10:   level_nxt = level_q + LW'(1);
      2'b01:   level_nxt = level_q - LW'(1);
      default: level_nxt = level_q;
    endcase
  end

  // The output register always mirrors the head entry; on a pop it advances to the
  // next stored entry, or to the incoming sample when the queue held only one word.
  always_comb begin
    head_nxt = head_q;
    if (pop) begin
      if (level_q > LW'(1)) begin
        head_nxt = mem[rd_ptr_q + AW'(1)];
      end else if (push) begin
        head_nxt = data_in;
      end
    end else if ((level_q == '0) && push) begin
      head_nxt = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_nxt;
      head_q  <= head_nxt;
      valid_q <= (level_nxt != '0);
    end
  end

  // A drop in the same cycle as clr_ovf restarts the count at one rather than zero.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (clr_ovf) begin
        drop_cnt_q <= DW'(1);
      end else if (drop_cnt_q != '1) begin
        drop_cnt_q <= drop_cnt_q + DW'(1);
      end
    end else if (clr_ovf) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  assign rd.out_data  = head_q;
  assign rd.out_valid = valid_q;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_slow_sample_fifo.sv
// Bench for slow_sample_fifo: directed stimulus, expected samples queued at issue time,
// a negedge monitor pops and compares every accepted output word.
module tb_slow_sample_fifo;
  localparam int S     = 12;
  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          clr_n;
  logic          en;
  logic [DW-1:0] decim;
  logic [S-1:0]  data_in;
  logic [LW-1:0] level;
  logic          overflow;
  logic [DW-1:0] drop_cnt;
  logic          clr_ovf;

  slow_sample_fifo_if #(.S(S)) rd_if ();

  slow_sample_fifo #(.S(S), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .en       (en),
    .decim    (decim),
    .data_in  (data_in),
    .rd       (rd_if.master),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .clr_ovf  (clr_ovf)
  );

  int checks   = 0;
  int failures = 0;
  logic [S-1:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: time limit reached, required finish before 200000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks: all assume entry at #1 after a rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_run(input int first, input int count);
    for (int k = 0; k < count; k++) begin
      data_in = S'(first + k);
      en      = 1'b1;
      step();
    end
    en = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    bit done;
    done = 1'b0;
    rd_if.out_ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!rd_if.out_valid) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s: out_valid still 1 after 100 cycles, required 0", name);
    end
    step();
    rd_if.out_ready = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [S-1:0] exp;
    if (clr_n && rd_if.out_valid && rd_if.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL mon_extra: got %0h with no expected sample", rd_if.out_data);
      end else begin
        exp = exp_q.pop_front();
        if (rd_if.out_data !== exp) begin
          failures++;
          $display("FAIL mon_data: got %0h expected %0h", rd_if.out_data, exp);
        end
      end
    end
  end

  initial begin
    clr_n = 1'b0; en = 1'b1; decim = DW'(1); data_in = 12'hABC;
    rd_if.out_ready = 1'b0; clr_ovf = 1'b0;

    // reset holds everything clear even with en=1
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(rd_if.out_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    check("rst_data", 32'(rd_if.out_data), 0);
    clr_n = 1'b1;
    exp_q.push_back(12'hABC);
    step();
    en = 1'b0;
    check("first_push_level", 32'(level), 1);
    check("first_push_valid", 32'(rd_if.out_valid), 1);
    check("first_push_data", 32'(rd_if.out_data), 32'h0ABC);
    wait_empty("drain_first");

    // decimate by 3: samples 0..11 -> keep 0,3,6,9
    decim = DW'(3);
    rd_if.out_ready = 1'b1;
    exp_q.push_back(12'd0); exp_q.push_back(12'd3);
    exp_q.push_back(12'd6); exp_q.push_back(12'd9);
    drive_run(0, 12);
    wait_empty("drain_decim3");

    // decim=0 keeps every sample
    decim = DW'(0);
    rd_if.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(S'(100 + k));
    drive_run(100, 4);
    wait_empty("drain_decim0");

    // fill with reader stalled: 20 pushes, 16 stored, 4 dropped
    decim = DW'(1);
    for (int k = 0; k < 16; k++) exp_q.push_back(S'(200 + k));
    drive_run(200, 20);
    check("fill_level", 32'(level), 16);
    check("fill_ovf", 32'(overflow), 1);
    check("fill_drop", 32'(drop_cnt), 4);
    check("fill_head", 32'(rd_if.out_data), 200);

    // full with simultaneous pop: every push is accepted
    rd_if.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(S'(300 + k));
    for (int k = 0; k < 8; k++) begin
      data_in = S'(300 + k);
      en = 1'b1;
      step();
    end
    en = 1'b0;
    rd_if.out_ready = 1'b0;
    check("fullpop_level", 32'(level), 16);
    check("fullpop_drop", 32'(drop_cnt), 4);
    check("fullpop_head", 32'(rd_if.out_data), 208);

    // clr_ovf coinciding with a drop: the drop wins
    data_in = 12'd400;
    en = 1'b1; clr_ovf = 1'b1;
    step();
    en = 1'b0; clr_ovf = 1'b0;
    check("clr_drop_ovf", 32'(overflow), 1);
    check("clr_drop_cnt", 32'(drop_cnt), 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("clr_only_ovf", 32'(overflow), 0);
    check("clr_only_cnt", 32'(drop_cnt), 0);
    check("clr_only_level", 32'(level), 16);

    // 300 drops saturate the counter
    en = 1'b1;
    repeat (300) step();
    check("sat_drop", 32'(drop_cnt), 32'hFF);
    check("sat_ovf", 32'(overflow), 1);

    // async reset mid-burst clears outputs before the next edge
    #2;
    clr_n = 1'b0;
    #1;
    check("async_valid", 32'(rd_if.out_valid), 0);
    check("async_level", 32'(level), 0);
    check("async_ovf", 32'(overflow), 0);
    check("async_drop", 32'(drop_cnt), 0);
    check("async_data", 32'(rd_if.out_data), 0);
    exp_q.delete();
    en = 1'b0;
    step();
    clr_n = 1'b1;

    // queue usable again after reset
    data_in = 12'h5A5;
    exp_q.push_back(12'h5A5);
    en = 1'b1;
    step();
    en = 1'b0;
    check("post_rst_level", 32'(level), 1);
    check("post_rst_data", 32'(rd_if.out_data), 32'h05A5);
    wait_empty("drain_post_rst");

    check("exp_q_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
